// File: rtl/prv32_div_seq_pkg.sv
// Shared definitions for the sequential RV32M divider: op encodings and widths.
package prv32_div_seq_pkg;

    localparam int unsigned DIV_XLEN  = 32;
    localparam int unsigned DIV_CNT_W = 5;

    // M-extension divide op encodings, shared with the rest of the execute stage
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    // bit 0 clear selects the signed variants (DIV, REM)
    function automatic logic div_op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // bit 1 set selects the remainder variants (REM, REMU)
    function automatic logic div_op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/prv32_div_step.sv
// One restoring shift-subtract step on a W+1 bit partial remainder.
module prv32_div_step #(
    parameter int unsigned W = 32
) (
    input  logic [W:0]   rem_in,
    input  logic         dvd_msb,
    input  logic [W-1:0] divisor,
    output logic         qbit,
    output logic [W:0]   rem_out
);

    logic [W+1:0] rem_sh;
    logic [W+1:0] diff;

    // shift in the next dividend bit, keep the difference only when it did not borrow
    always_comb begin
        rem_sh  = {rem_in, dvd_msb};
        diff    = rem_sh - {2'b00, divisor};
        qbit    = ~diff[W+1];
        rem_out = qbit ? diff[W:0] : rem_sh[W:0];
    end

endmodule

// File: rtl/prv32_div_seq.sv
// Multi-cycle RV32M divider: 32 restoring steps, special cases bypass the loop.
module prv32_div_seq
    import prv32_div_seq_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e                 state;
    logic [DIV_CNT_W-1:0]   cnt;
    logic [1:0]             op_q;
    logic [XLEN-1:0]        dvd_q;
    logic [XLEN-1:0]        dvs_q;
    logic [XLEN:0]          rem_q;
    logic                   neg_quo_q;
    logic                   neg_rem_q;

    logic                   a_neg;
    logic                   b_neg;
    logic [XLEN-1:0]        a_mag;
    logic [XLEN-1:0]        b_mag;
    logic                   div0;
    logic                   ovf;
    logic                   qbit;
    logic [XLEN:0]          rem_nx;
    logic [XLEN-1:0]        quo_fix;
    logic [XLEN-1:0]        rem_fix;
    logic [XLEN-1:0]        res_c;

    // operand magnitudes and special-case detection at latch time
    always_comb begin
        a_neg = div_op_signed(op) & a[XLEN-1];
        b_neg = div_op_signed(op) & b[XLEN-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        div0  = (b == '0);
        ovf   = div_op_signed(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    end

    prv32_div_step #(.W(XLEN)) u_step (
        .rem_in  (rem_q),
        .dvd_msb (dvd_q[XLEN-1]),
        .divisor (dvs_q),
        .qbit    (qbit),
        .rem_out (rem_nx)
    );

    // sign correction and quotient/remainder selection for the final result
    always_comb begin
        quo_fix = neg_quo_q ? -dvd_q : dvd_q;
        rem_fix = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        res_c   = div_op_is_rem(op_q) ? rem_fix : quo_fix;
    end

    // control FSM with operand, iteration and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            result    <= '0;
        end else begin
            valid <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            op_q  <= op;
                            dvs_q <= b_mag;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            if (div0) begin
                                // divide by zero wins over overflow
                                dvd_q     <= '1;
                                rem_q     <= {1'b0, a};
                                neg_quo_q <= 1'b0;
                                neg_rem_q <= 1'b0;
                                state     <= S_DONE;
                            end else if (ovf) begin
                                dvd_q     <= {1'b1, {(XLEN-1){1'b0}}};
                                rem_q     <= '0;
                                neg_quo_q <= 1'b0;
                                neg_rem_q <= 1'b0;
                                state     <= S_DONE;
                            end else begin
                                dvd_q     <= a_mag;
                                rem_q     <= '0;
                                neg_quo_q <= a_neg ^ b_neg;
                                neg_rem_q <= a_neg;
                                state     <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        // dividend register fills with quotient bits from the right
                        dvd_q <= {dvd_q[XLEN-2:0], qbit};
                        rem_q <= rem_nx;
                        cnt   <= cnt + DIV_CNT_W'(1);
                        if (cnt == DIV_CNT_W'(XLEN-1)) begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        valid  <= 1'b1;
                        result <= res_c;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prv32_div_seq.sv
// Randomized self-checking bench for prv32_div_seq against an arithmetic reference.
module tb_prv32_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int n_pass = 0;
    int n_chk  = 0;
    logic [31:0] last_res;

    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    prv32_div_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // RV32M semantics written directly with SystemVerilog arithmetic
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic sgn;
        logic rem;
        sgn = (o == 2'b00) || (o == 2'b10);
        rem = (o == 2'b10) || (o == 2'b11);
        if (y == 32'd0) return rem ? x : 32'hFFFF_FFFF;
        if (sgn && x == MIN_INT && y == 32'hFFFF_FFFF) return rem ? 32'd0 : MIN_INT;
        case (o)
            2'b00:   return 32'($signed(x) / $signed(y));
            2'b01:   return x / y;
            2'b10:   return 32'($signed(x) % $signed(y));
            default: return x % y;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return (y == 32'd0) || ((o == 2'b00 || o == 2'b10) && x == MIN_INT && y == 32'hFFFF_FFFF);
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit mid_start);
        logic [31:0] exp;
        int lat;
        bit busy_ok;
        exp = ref_model(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (!busy) busy_ok = 1'b0;
            if (mid_start && n == 5) begin
                start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd3;
            end
            if (mid_start && n == 6) start = 1'b0;
            @(posedge clk);
            #1;
            if (valid) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        chk("latency", 32'(lat), is_special(o, x, y) ? 32'd1 : 32'd33);
        chk("result", result, exp);
        chk("busy_while_run", 32'(busy_ok), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", 32'(valid), 32'd0);
        chk("result_hold", result, exp);
        last_res = exp;
    endtask

    task automatic watch_no_valid(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        last_res = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_result", result, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // directed corner cases
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(2'b01, 32'd100, 32'd7, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        run_op(2'b00, 32'd5, 32'd0, 1'b0);
        run_op(2'b10, 32'd5, 32'd0, 1'b0);
        run_op(2'b01, 32'hDEAD_BEEF, 32'd0, 1'b0);
        run_op(2'b00, MIN_INT, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, MIN_INT, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b01, MIN_INT, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // start while busy is ignored
        run_op(2'b01, 32'd1000, 32'd3, 1'b1);

        // randomized operands with biased divisors
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       begin ra = MIN_INT; rb = 32'hFFFF_FFFF; end
                3:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 1'b0);
        end

        // flush at run cycle 10
        @(negedge clk);
        op = 2'b01; a = 32'd12345; b = 32'd17; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        watch_no_valid("flush_no_valid");
        chk("flush_result_kept", result, last_res);

        // flush and start together in idle
        @(negedge clk);
        op = 2'b00; a = 32'd50; b = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        watch_no_valid("flush_start_no_valid");

        // async reset mid-run
        @(negedge clk);
        op = 2'b11; a = 32'd999; b = 32'd10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_valid("arst_no_valid");

        // recovery after reset
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prv32_div_seq.md
PRV32_DIV_SEQ -- requirements
Module: prv32_div_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port a  input  32  dividend (rs1).
REQ-007 SHALL have port b  input  32  divisor (rs2).
REQ-008 SHALL have port flush  input  1  kills any in-flight operation.
REQ-009 SHALL have port busy  output  1  high whenever state != IDLE; pipeline stall source.
REQ-010 SHALL have port valid  output  1  one-cycle pulse, result available.
REQ-011 SHALL have port result  output  32  quotient or remainder per latched op.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 and flush=0 SHALL latch op, a, b and transition to RUN, or to DONE when a special case applies.
REQ-014 Signed ops SHALL convert operands to magnitudes at latch time; quotient sign = a[31]^b[31], remainder sign = a[31].
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle under a 5-bit counter, 32 steps, then go to DONE.
REQ-016 Normal latency: start sampled at edge t0 -> valid high in cycle following edge t0+33.
REQ-017 Divisor zero SHALL skip RUN: quotient 0xFFFFFFFF (all ops), remainder = a unmodified; valid after edge t0+1.
REQ-018 Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF) SHALL skip RUN: quotient 0x80000000, remainder 0.
REQ-019 Divide-by-zero SHALL take precedence over overflow detection.
REQ-020 DONE SHALL assert valid for exactly one cycle, apply sign correction to the result, then return to IDLE.
REQ-021 result SHALL hold its last value until the next DONE; valid SHALL be 0 outside DONE.
REQ-022 start while busy=1 SHALL be ignored with no queuing.
REQ-023 flush=1 in any state SHALL force IDLE at the next edge with no valid pulse; result is unchanged.
REQ-024 flush and start in the same IDLE cycle: flush SHALL win and the request is dropped.
REQ-025 Remainder arithmetic SHALL use a 33-bit partial remainder to avoid carry loss.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, counter 0, busy 0, valid 0, result 0, and all operand registers 0.
REQ-027 Reset assertion mid-RUN SHALL abandon the operation with no valid pulse after release.

Structure
REQ-028 The op encodings (DIV/DIVU/REM/REMU) SHALL be defined in the shared defines.v beside the ALU_* codes.
REQ-029 The FSM state encodings SHALL remain local to the module.
REQ-030 One restoring step SHALL be a combinational sub-module prv32_div_step (33-bit remainder in, quotient bit and next remainder out).

Verification
REQ-031 DIV a=7, b=0xFFFFFFFE (-2) -> valid at t0+33, result 0xFFFFFFFD; REM on the same operands -> 0x00000001.
REQ-032 DIVU a=100, b=7 -> result 14; REMU -> 2; busy high for cycles t0+1..t0+33.
REQ-033 DIV a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5; each valid one cycle after start.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0; latency as in REQ-033.
REQ-035 flush at RUN cycle 10 -> busy 0 next cycle, no valid, result unchanged; a second start issued mid-RUN -> ignored.
REQ-036 rst_n low mid-RUN -> outputs zero immediately (async); no valid after release.
